// File: rtl/loss_detector.sv
// loss_detector -- game supervisor for the bird column.
//
// Runs the IDLE/PLAY/OVER game FSM, detects collisions, fall-off and pipe
// passes on each game tick, and keeps a saturating 2-digit BCD score.
//
// Ports:
//   clock       in   system clock
//   reset       in   synchronous, active-high
//   KEY0        in   flap/start button, active-high, already synchronized
//   birdCol     in   [7:0] bird cell lightOn vector, bit7 = top row
//   pipeCol     in   [7:0] pipe pixels in the bird column, bit7 = top row
//   lossDetect  out  1 while in OVER (fans out to every bird cell)
//   playing     out  1 while in PLAY
//   score       out  [7:0] BCD score, [7:4] tens, [3:0] units
//
// Optional feature: define CEILING_LOSS_EN to make the top row
// (birdCol[7]) a losing position during PLAY.

module loss_detector #(
    parameter logic [10:0] TICK_MAX    = 11'd1791,
    parameter int          EMPTY_TICKS = 2,
    parameter int          OVER_HOLD   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       KEY0,
    input  logic [7:0] birdCol,
    input  logic [7:0] pipeCol,
    output logic       lossDetect,
    output logic       playing,
    output logic [7:0] score
);

    localparam int EW = $clog2(EMPTY_TICKS + 1);
    localparam int HW = $clog2(OVER_HOLD + 1);
    localparam logic [EW-1:0] EMPTY_MAX = EW'(EMPTY_TICKS);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(OVER_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    state_t        state_q;
    logic [10:0]   div_q;
    logic          key_q;
    logic [7:0]    pipe_q;
    logic [EW-1:0] empty_q;
    logic [HW-1:0] hold_q;
    logic [7:0]    score_q;
    logic          loss_q;
    logic          play_q;

    logic          tick;
    logic          press;
    logic          bird_empty;
    logic [EW-1:0] empty_d;
    logic          fall_off;
    logic          collision;
    logic          ceiling;
    logic          loss;
    logic          pass;
    logic [7:0]    score_d;

    assign tick  = (div_q == TICK_MAX);
    assign press = KEY0 & ~key_q;

    assign bird_empty = (birdCol == 8'h00);
    assign empty_d    = empty_q + EW'(1);
    assign fall_off   = bird_empty && (empty_d >= EMPTY_MAX);
    assign collision  = |(birdCol & pipeCol);

`ifdef CEILING_LOSS_EN
    assign ceiling = birdCol[7];
`else
    assign ceiling = 1'b0;
`endif

    assign loss = collision | ceiling | fall_off;
    // A pipe has been cleared when the column goes from occupied to empty.
    assign pass = (pipe_q != 8'h00) && (pipeCol == 8'h00);

    // Saturating BCD increment.
    always_comb begin
        score_d = score_q;
        if (score_q != 8'h99) begin
            if (score_q[3:0] == 4'd9) begin
                score_d = {score_q[7:4] + 4'd1, 4'd0};
            end else begin
                score_d = {score_q[7:4], score_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            key_q   <= 1'b0;
            pipe_q  <= '0;
            empty_q <= '0;
            hold_q  <= '0;
            score_q <= 8'h00;
            loss_q  <= 1'b0;
            play_q  <= 1'b0;
        end else begin
            div_q <= tick ? 11'd0 : div_q + 11'd1;
            key_q <= KEY0;
            if (tick) pipe_q <= pipeCol;

            case (state_q)
                IDLE: begin
                    loss_q <= 1'b0;
                    play_q <= 1'b0;
                    if (press) begin
                        state_q <= PLAY;
                        play_q  <= 1'b1;
                        score_q <= 8'h00;
                        empty_q <= '0;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        empty_q <= bird_empty ? empty_d : '0;
                        if (loss) begin
                            // Loss beats a simultaneous pass: score not bumped.
                            state_q <= OVER;
                            loss_q  <= 1'b1;
                            play_q  <= 1'b0;
                            hold_q  <= '0;
                        end else if (pass) begin
                            score_q <= score_d;
                        end
                    end
                end
                OVER: begin
                    if (press && hold_q == HOLD_MAX) begin
                        state_q <= IDLE;
                        loss_q  <= 1'b0;
                    end else if (tick && hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    loss_q  <= 1'b0;
                    play_q  <= 1'b0;
                end
            endcase
        end
    end

    assign lossDetect = loss_q;
    assign playing    = play_q;
    assign score      = score_q;

endmodule

// File: tb/tb_loss_detector.sv
// Scoreboard bench for loss_detector (TICK_MAX=3, EMPTY_TICKS=2, OVER_HOLD=4).
// Stimulus pushes expected outputs into a queue; a negedge monitor pops and
// compares them against the DUT.

module tb_loss_detector;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       KEY0 = 1'b0;
    logic [7:0] birdCol = 8'h00;
    logic [7:0] pipeCol = 8'h00;
    logic       lossDetect;
    logic       playing;
    logic [7:0] score;

    loss_detector #(
        .TICK_MAX   (11'd3),
        .EMPTY_TICKS(2),
        .OVER_HOLD  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .KEY0      (KEY0),
        .birdCol   (birdCol),
        .pipeCol   (pipeCol),
        .lossDetect(lossDetect),
        .playing   (playing),
        .score     (score)
    );

    always #5 clock = ~clock;

    // Bench-side copy of the game-tick divider, used only for stimulus timing.
    logic [1:0] tdiv;
    always @(posedge clock) begin
        if (reset) tdiv <= 2'd0;
        else       tdiv <= tdiv + 2'd1;
    end

    typedef struct {
        string      name;
        logic       ld;
        logic       pl;
        logic [7:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: compare every pending expectation at the negedge.
    always @(negedge clock) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (lossDetect !== e.ld || playing !== e.pl || score !== e.sc) begin
                errors++;
                $display("FAIL %s: got lossDetect=%b playing=%b score=%h, want lossDetect=%b playing=%b score=%h",
                         e.name, lossDetect, playing, score, e.ld, e.pl, e.sc);
            end
        end
    end

    task automatic chk(input string name, input logic ld, input logic pl, input logic [7:0] sc);
        exp_t e;
        e.name = name; e.ld = ld; e.pl = pl; e.sc = sc;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Advance until just after the next tick edge.
    task automatic do_tick();
        while (tdiv != 2'd3) step();
        step();
    endtask

    task automatic press();
        KEY0 = 1'b1;
        step();
        KEY0 = 1'b0;
    endtask

    task automatic do_pass();
        pipeCol = 8'hE7;
        do_tick();
        pipeCol = 8'h00;
        do_tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) step();
        reset = 1'b0;
        chk("reset", 1'b0, 1'b0, 8'h00);
        step();

        // Start, score to 05, then reset mid-play
        birdCol = 8'h10;
        press();
        chk("start", 1'b0, 1'b1, 8'h00);
        step();
        pipeCol = 8'hE7;
        do_tick();
        do_tick();
        pipeCol = 8'h00;
        do_tick();
        chk("first_pass", 1'b0, 1'b1, 8'h01);
        repeat (4) do_pass();
        chk("score05", 1'b0, 1'b1, 8'h05);
        reset = 1'b1;
        step();
        chk("reset_mid_play", 1'b0, 1'b0, 8'h00);
        reset = 1'b0;
        step();

        // Scoring through carry and saturation
        press();
        chk("start_b", 1'b0, 1'b1, 8'h00);
        step();
        repeat (9) do_pass();
        chk("score09", 1'b0, 1'b1, 8'h09);
        do_pass();
        chk("score10_carry", 1'b0, 1'b1, 8'h10);
        repeat (89) do_pass();
        chk("score99", 1'b0, 1'b1, 8'h99);
        do_pass();
        chk("score_saturate", 1'b0, 1'b1, 8'h99);

        // Collision with one clock latency
        birdCol = 8'h08;
        pipeCol = 8'h0F;
        while (tdiv != 2'd3) step();
        chk("coll_pre_edge", 1'b0, 1'b1, 8'h99);
        step();
        chk("coll_post_edge", 1'b1, 1'b0, 8'h99);
        birdCol = 8'h10;
        pipeCol = 8'h00;

        // Restart hold
        do_tick();
        do_tick();
        press();
        step();
        chk("early_press_ignored", 1'b1, 1'b0, 8'h99);
        do_tick();
        do_tick();
        KEY0 = 1'b1;
        step();
        chk("restart", 1'b0, 1'b0, 8'h99);
        repeat (8) step();
        chk("held_key_one_press", 1'b0, 1'b0, 8'h99);
        KEY0 = 1'b0;
        step();

        // Fall-off recovery, then fall-off together with a pass
        press();
        chk("start_c", 1'b0, 1'b1, 8'h00);
        step();
        birdCol = 8'h00;
        do_tick();
        chk("empty_one_tick", 1'b0, 1'b1, 8'h00);
        birdCol = 8'h01;
        do_tick();
        chk("recover", 1'b0, 1'b1, 8'h00);
        birdCol = 8'h00;
        pipeCol = 8'hE7;
        do_tick();
        chk("empty_again", 1'b0, 1'b1, 8'h00);
        pipeCol = 8'h00;
        do_tick();
        chk("fall_off_beats_pass", 1'b1, 1'b0, 8'h00);

        // Ceiling row
        repeat (4) do_tick();
        press();
        chk("restart_c", 1'b0, 1'b0, 8'h00);
        step();
        birdCol = 8'h10;
        press();
        chk("start_d", 1'b0, 1'b1, 8'h00);
        step();
        birdCol = 8'h80;
        do_tick();
`ifdef CEILING_LOSS_EN
        chk("ceiling_loss", 1'b1, 1'b0, 8'h00);
`else
        chk("ceiling_legal", 1'b0, 1'b1, 8'h00);
`endif

        step();
        step();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
